// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle SRAM between IF and MEM requests, sequencing accesses and driving pipeline freezes
module mem_port_arbiter #(
  parameter int SRAM_WAIT    = 3,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_freeze,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_freeze,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_re,
  output logic        sram_we,
  input  logic [31:0] sram_rdata
);
  localparam int WW = $clog2(SRAM_WAIT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic owner_mem, op_wr, mem_req, any_req, grant_mem, last;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  assign mem_req   = mem_rd_en | mem_wr_en;
  assign any_req   = if_req | mem_req;
  assign grant_mem = mem_req & ~(if_req & (starve_cnt == SW'(STARVE_LIMIT)));
  assign last      = wait_cnt == WW'(SRAM_WAIT - 1);
  always_comb begin
    state_n = state == IDLE   ? (any_req ? ACCESS : IDLE) :
              state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_mem  <= 1'b0;
      op_wr      <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner_mem  <= grant_mem;
        op_wr      <= grant_mem & mem_wr_en;
        sram_addr  <= grant_mem ? mem_addr : if_addr;
        sram_wdata <= grant_mem ? mem_wdata : '0;
        wait_cnt   <= '0;
        starve_cnt <= !grant_mem ? '0 :
                      (if_req && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
      end
      if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (last && !op_wr && owner_mem) mem_rdata <= sram_rdata;
        if (last && !op_wr && !owner_mem) if_rdata <= sram_rdata;
      end
    end
  end
  assign sram_re    = (state == ACCESS) & ~op_wr;
  assign sram_we    = (state == ACCESS) & op_wr;
  assign if_ready   = (state == DONE) & ~owner_mem;
  assign mem_ready  = (state == DONE) & owner_mem;
  assign if_freeze  = if_req & ~if_ready;
  assign mem_freeze = mem_req & ~mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and scoreboard-checked bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int SRAM_WAIT = 3;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, sram_rdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  logic        if_ready, if_freeze, mem_ready, mem_freeze, sram_re, sram_we;
  always #5 clk = ~clk;
  mem_port_arbiter #(.SRAM_WAIT(SRAM_WAIT), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_freeze(if_freeze), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_freeze(mem_freeze), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_re(sram_re), .sram_we(sram_we), .sram_rdata(sram_rdata)
  );
  function automatic logic [31:0] sram_f(input logic [31:0] a);
    return a == 32'h10 ? 32'hE3A01005 : (a ^ 32'h5A5A_C3C3) + 32'h1111;
  endfunction
  int acc_n = 0;
  always @(posedge clk) acc_n <= (sram_re | sram_we) ? acc_n + 1 : 0;
  assign sram_rdata = (sram_re && acc_n == SRAM_WAIT - 1) ? sram_f(sram_addr) : 32'hBAD0_BAD0;
  typedef struct {bit mem; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int cyc;} exp_t;
  typedef struct {bit mem; bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t vt[8];
  int n_chk = 0, n_fail = 0, cyc = 0, strobes = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input bit mem, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int due);
    exp_t x;
    x.mem = mem; x.wr = wr; x.addr = addr; x.wdata = wdata; x.rdata = rdata; x.cyc = due;
    q.push_back(x);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ready(input bit mem);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem ? mem_ready : if_ready) && n < 20);
    check("ready_timeout", n < 20, 1);
  endtask
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (sram_re | sram_we) begin
      strobes++;
      if (q.size() == 0) check("stray_strobe", 1, 0);
      else begin
        check("sram_addr", sram_addr, q[0].addr);
        check("sram_we", sram_we, q[0].wr);
        if (q[0].wr) check("sram_wdata", sram_wdata, q[0].wdata);
      end
    end
    if (if_ready | mem_ready) begin
      if (q.size() == 0) check("stray_ready", 1, 0);
      else begin
        e = q.pop_front();
        check("ready_port", {if_ready, mem_ready}, {~e.mem, e.mem});
        check("ready_cycle", cyc, e.cyc);
        check("strobe_count", strobes, SRAM_WAIT);
        check(e.mem ? "mem_rdata" : "if_rdata", e.mem ? mem_rdata : if_rdata, e.rdata);
      end
      strobes = 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int c;
    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hE3A01005};
    vt[1] = '{1'b1, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h0, sram_f(32'h400)};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'h0, sram_f(32'h14)};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h800, 32'h12345678, sram_f(32'h400)};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0, sram_f(32'h0)};
    vt[6] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, sram_f(32'hFFFF_FFFC)};
    vt[7] = '{1'b1, 1'b0, 1'b1, 32'hC, 32'hA5A5A5A5, sram_f(32'h0)};
    tick(3);
    check("rst_ctrl", {if_ready, mem_ready, sram_re, sram_we, if_freeze, mem_freeze}, 0);
    check("rst_data", if_rdata | mem_rdata | sram_addr | sram_wdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vt[i].mem) begin
        mem_rd_en = vt[i].rd; mem_wr_en = vt[i].wr; mem_addr = vt[i].addr; mem_wdata = vt[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vt[i].addr;
      end
      push(vt[i].mem, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, cyc + SRAM_WAIT + 1);
      #1;
      check("freeze_req", {if_freeze, mem_freeze}, {~vt[i].mem, vt[i].mem});
      wait_ready(vt[i].mem);
      check("freeze_ready", {if_freeze, mem_freeze}, 0);
      if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    end
    @(negedge clk);
    c = cyc;
    if_req = 1'b1; if_addr = 32'h50; mem_rd_en = 1'b1; mem_addr = 32'h600;
    push(1, 0, 32'h600, 0, sram_f(32'h600), c + 4);
    push(1, 0, 32'h604, 0, sram_f(32'h604), c + 9);
    push(0, 0, 32'h50, 0, sram_f(32'h50), c + 14);
    push(1, 0, 32'h608, 0, sram_f(32'h608), c + 19);
    wait_ready(1);
    mem_addr = 32'h604;
    wait_ready(1);
    mem_addr = 32'h608;
    wait_ready(0);
    if_req = 1'b0;
    wait_ready(1);
    mem_rd_en = 1'b0;
    @(negedge clk);
    c = cyc;
    if_req = 1'b1; if_addr = 32'h30; mem_rd_en = 1'b1; mem_addr = 32'h440;
    push(1, 0, 32'h440, 0, sram_f(32'h440), c + 4);
    push(0, 0, 32'h30, 0, sram_f(32'h30), c + 9);
    wait_ready(1);
    mem_rd_en = 1'b0;
    wait_ready(0);
    if_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h70;
    push(0, 0, 32'h70, 0, sram_f(32'h70), cyc + 4);
    tick(2);
    rst = 1'b1;
    q.delete();
    strobes = 0;
    tick(1);
    check("midrst_ctrl", {if_ready, mem_ready, sram_re, sram_we}, 0);
    check("midrst_data", if_rdata | mem_rdata | sram_addr | sram_wdata, 0);
    rst = 1'b0;
    push(0, 0, 32'h70, 0, sram_f(32'h70), cyc + 4);
    wait_ready(0);
    if_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h90;
    push(0, 0, 32'h90, 0, sram_f(32'h90), cyc + 4);
    tick(2);
    if_req = 1'b0;
    #1;
    check("flush_freeze", if_freeze, 0);
    tick(10);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
